// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bundle: ALU and load return paths
// sharing the register file write port.
interface regfile_wb_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  alu_valid;
  logic                  alu_ready;
  logic [ADDR_WIDTH-1:0] alu_addr;
  logic [DATA_WIDTH-1:0] alu_data;
  logic                  mem_valid;
  logic                  mem_ready;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data;

  modport master (
    output alu_valid, alu_addr, alu_data,
    output mem_valid, mem_addr, mem_data,
    input  alu_ready, mem_ready
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data,
    input  mem_valid, mem_addr, mem_data,
    output alu_ready, mem_ready
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Write-port arbiter with anti-starvation counter and
// per-register busy scoreboard for RAW hazard detection.
module regfile_wb_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 5,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  regfile_wb_arbiter_if.slave        wb,
  input  logic                       issue_valid,
  input  logic [ADDR_WIDTH-1:0]      issue_addr,
  input  logic [ADDR_WIDTH-1:0]      read_addr1,
  input  logic [ADDR_WIDTH-1:0]      read_addr2,
  output logic                       hazard1,
  output logic                       hazard2,
  output logic                       write_enable,
  output logic [ADDR_WIDTH-1:0]      write_addr,
  output logic [DATA_WIDTH-1:0]      write_data,
  output logic [(1<<ADDR_WIDTH)-1:0] busy_mask
);
  localparam int NREG = 1 << ADDR_WIDTH;
  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  logic [2:0]            starve_q, starve_d;
  logic [NREG-1:0]       busy_q, busy_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  logic                  alu_win, mem_win, xfer;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_data;

  always_comb begin
    alu_win = wb.alu_valid &&
              (!wb.mem_valid || starve_q == LIMIT);
    mem_win = wb.mem_valid && !alu_win;
    wb.alu_ready = alu_win && !rst;
    wb.mem_ready = mem_win && !rst;
    xfer     = wb.alu_ready || wb.mem_ready;
    win_addr = alu_win ? wb.alu_addr : wb.mem_addr;
    win_data = alu_win ? wb.alu_data : wb.mem_data;
  end

  always_comb begin
    starve_d = '0;
    busy_d   = busy_q;
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    if (wb.alu_valid && !wb.alu_ready)
      starve_d = (starve_q >= LIMIT) ? LIMIT : starve_q + 3'd1;
    if (xfer) begin
      we_d     = (win_addr != '0);
      waddr_d  = win_addr;
      wdata_d  = win_data;
      busy_d[win_addr] = 1'b0;
    end
    // Issue applied last so a same-address set beats the clear
    if (issue_valid && issue_addr != '0)
      busy_d[issue_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
      busy_q   <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      starve_q <= starve_d;
      busy_q   <= busy_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign hazard1      = busy_q[read_addr1];
  assign hazard2      = busy_q[read_addr2];
  assign write_enable = we_q;
  assign write_addr   = waddr_q;
  assign write_data   = wdata_q;
  assign busy_mask    = busy_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: grants, starvation,
// register 0, scoreboard collisions and mid-run reset.
module tb_regfile_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic [4:0]  issue_addr;
  logic [4:0]  read_addr1;
  logic [4:0]  read_addr2;
  logic        hazard1;
  logic        hazard2;
  logic        write_enable;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic [31:0] busy_mask;

  int n_cmp = 0;
  int n_err = 0;

  regfile_wb_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) wb ();

  regfile_wb_arbiter #(
    .DATA_WIDTH(32), .ADDR_WIDTH(5), .STARVE_LIMIT(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wb(wb),
    .issue_valid(issue_valid),
    .issue_addr(issue_addr),
    .read_addr1(read_addr1),
    .read_addr2(read_addr2),
    .hazard1(hazard1),
    .hazard2(hazard2),
    .write_enable(write_enable),
    .write_addr(write_addr),
    .write_data(write_data),
    .busy_mask(busy_mask)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst          = 1'b1;
    issue_valid  = 1'b0;
    issue_addr   = '0;
    read_addr1   = '0;
    read_addr2   = '0;
    wb.alu_valid = 1'b1;
    wb.alu_addr  = 5'd4;
    wb.alu_data  = 32'h1;
    wb.mem_valid = 1'b0;
    wb.mem_addr  = '0;
    wb.mem_data  = '0;

    // reset, alu requesting
    #1;
    chk("rst_alu_ready0", 32'(wb.alu_ready), 32'd0);
    tick();
    chk("rst_we", 32'(write_enable), 32'd0);
    chk("rst_busy", busy_mask, 32'd0);
    chk("rst_haz1", 32'(hazard1), 32'd0);
    chk("rst_haz2", 32'(hazard2), 32'd0);
    chk("rst_waddr", 32'(write_addr), 32'd0);
    chk("rst_wdata", write_data, 32'd0);
    tick();
    chk("rst_alu_ready1", 32'(wb.alu_ready), 32'd0);
    chk("rst_we1", 32'(write_enable), 32'd0);

    // single write to r5
    rst          = 1'b0;
    wb.alu_valid = 1'b0;
    issue_valid  = 1'b1;
    issue_addr   = 5'd5;
    tick();
    issue_valid = 1'b0;
    read_addr1  = 5'd5;
    #1;
    chk("iss5_busy", busy_mask, 32'h0000_0020);
    chk("iss5_haz1", 32'(hazard1), 32'd1);
    wb.alu_valid = 1'b1;
    wb.alu_addr  = 5'd5;
    wb.alu_data  = 32'h100;
    #1;
    chk("wr5_ready", 32'(wb.alu_ready), 32'd1);
    tick();
    wb.alu_valid = 1'b0;
    #1;
    chk("wr5_we", 32'(write_enable), 32'd1);
    chk("wr5_waddr", 32'(write_addr), 32'd5);
    chk("wr5_wdata", write_data, 32'h100);
    chk("wr5_haz1", 32'(hazard1), 32'd0);
    chk("wr5_busy", busy_mask, 32'd0);

    // both valid: M M M A M M M A
    wb.alu_valid = 1'b1;
    wb.alu_addr  = 5'd7;
    wb.alu_data  = 32'hAAAA;
    wb.mem_valid = 1'b1;
    wb.mem_addr  = 5'd8;
    wb.mem_data  = 32'hBBBB;
    for (int i = 0; i < 8; i++) begin
      logic a_exp;
      a_exp = (i == 3) || (i == 7);
      #1;
      chk($sformatf("starve%0d_alu", i), 32'(wb.alu_ready), 32'(a_exp));
      chk($sformatf("starve%0d_mem", i), 32'(wb.mem_ready), 32'(!a_exp));
      tick();
      chk($sformatf("starve%0d_waddr", i), 32'(write_addr),
          a_exp ? 32'd7 : 32'd8);
      chk($sformatf("starve%0d_wdata", i), write_data,
          a_exp ? 32'hAAAA : 32'hBBBB);
    end
    wb.alu_valid = 1'b0;
    wb.mem_valid = 1'b0;

    // register 0 write and issue
    wb.mem_valid = 1'b1;
    wb.mem_addr  = 5'd0;
    wb.mem_data  = 32'hFFFF_FFFF;
    issue_valid  = 1'b1;
    issue_addr   = 5'd0;
    #1;
    chk("r0_ready", 32'(wb.mem_ready), 32'd1);
    tick();
    wb.mem_valid = 1'b0;
    issue_valid  = 1'b0;
    #1;
    chk("r0_we", 32'(write_enable), 32'd0);
    chk("r0_wdata", write_data, 32'hFFFF_FFFF);
    chk("r0_busy", busy_mask, 32'd0);

    // set/clear collision on r16
    issue_valid = 1'b1;
    issue_addr  = 5'd16;
    tick();
    issue_valid = 1'b0;
    read_addr2  = 5'd16;
    #1;
    chk("c16_busy", busy_mask, 32'h0001_0000);
    chk("c16_haz2", 32'(hazard2), 32'd1);
    issue_valid  = 1'b1;
    wb.alu_valid = 1'b1;
    wb.alu_addr  = 5'd16;
    wb.alu_data  = 32'h55;
    #1;
    chk("c16_ready", 32'(wb.alu_ready), 32'd1);
    tick();
    issue_valid  = 1'b0;
    wb.alu_valid = 1'b0;
    #1;
    chk("c16_we", 32'(write_enable), 32'd1);
    chk("c16_waddr", 32'(write_addr), 32'd16);
    chk("c16_wdata", write_data, 32'h55);
    chk("c16_busy_kept", busy_mask, 32'h0001_0000);
    chk("c16_haz2_kept", 32'(hazard2), 32'd1);

    // set r2 while clearing r16
    issue_valid  = 1'b1;
    issue_addr   = 5'd2;
    wb.mem_valid = 1'b1;
    wb.mem_addr  = 5'd16;
    wb.mem_data  = 32'h66;
    tick();
    issue_valid  = 1'b0;
    wb.mem_valid = 1'b0;
    #1;
    chk("diff_busy", busy_mask, 32'h0000_0004);
    chk("diff_waddr", 32'(write_addr), 32'd16);
    chk("diff_haz2", 32'(hazard2), 32'd0);
    issue_valid = 1'b1;
    issue_addr  = 5'd8;
    tick();
    issue_valid = 1'b0;
    #1;
    chk("pre_rst_busy", busy_mask, 32'h0000_0104);

    // reset mid-operation
    wb.mem_valid = 1'b1;
    wb.mem_addr  = 5'd9;
    wb.mem_data  = 32'h99;
    rst          = 1'b1;
    #1;
    chk("mrst_ready", 32'(wb.mem_ready), 32'd0);
    tick();
    chk("mrst_busy", busy_mask, 32'd0);
    chk("mrst_we", 32'(write_enable), 32'd0);
    rst = 1'b0;
    #1;
    chk("mrst_ready_after", 32'(wb.mem_ready), 32'd1);
    tick();
    wb.mem_valid = 1'b0;
    #1;
    chk("mrst_we_after", 32'(write_enable), 32'd1);
    chk("mrst_waddr", 32'(write_addr), 32'd9);
    chk("mrst_wdata", write_data, 32'h99);
    chk("mrst_busy_after", busy_mask, 32'd0);

    // same address from both requesters
    wb.alu_valid = 1'b1;
    wb.alu_addr  = 5'd3;
    wb.alu_data  = 32'h11;
    wb.mem_valid = 1'b1;
    wb.mem_addr  = 5'd3;
    wb.mem_data  = 32'h22;
    #1;
    chk("same_mem_ready", 32'(wb.mem_ready), 32'd1);
    chk("same_alu_wait", 32'(wb.alu_ready), 32'd0);
    tick();
    wb.mem_valid = 1'b0;
    #1;
    chk("same_first", write_data, 32'h22);
    chk("same_alu_ready", 32'(wb.alu_ready), 32'd1);
    tick();
    wb.alu_valid = 1'b0;
    #1;
    chk("same_second", write_data, 32'h11);
    chk("same_waddr", 32'(write_addr), 32'd3);
    chk("same_we", 32'(write_enable), 32'd1);
    tick();
    chk("idle_we", 32'(write_enable), 32'd0);
    chk("idle_hold", write_data, 32'h11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the Register_File's single write port between two writeback requesters: the ALU result path and the load (memory) return path. It uses valid/ready handshakes and fixed priority with an anti-starvation counter. It also keeps a per-register busy scoreboard, set at issue and cleared at writeback, and exports read-after-write hazard flags for both Register_File read addresses. It sits between the execute/memory stages and Register_File, and drives write_addr/write_data/write_enable directly.

Parameters:
DATA_WIDTH, 32, width of write data
ADDR_WIDTH, 5, register address width (2**ADDR_WIDTH registers)
STARVE_LIMIT, 3, consecutive denied cycles after which ALU overrides memory priority (1..7)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
alu_valid  in  1  ALU writeback request
alu_ready  out  1  ALU request granted this cycle
alu_addr  in  ADDR_WIDTH  ALU destination register
alu_data  in  DATA_WIDTH  ALU result
mem_valid  in  1  load writeback request
mem_ready  out  1  load request granted this cycle
mem_addr  in  ADDR_WIDTH  load destination register
mem_data  in  DATA_WIDTH  load data
issue_valid  in  1  instruction issued with a destination register
issue_addr  in  ADDR_WIDTH  destination of issued instruction
read_addr1  in  ADDR_WIDTH  mirror of Register_File read_addr1
read_addr2  in  ADDR_WIDTH  mirror of Register_File read_addr2
hazard1  out  1  register at read_addr1 has a pending write
hazard2  out  1  register at read_addr2 has a pending write
write_enable  out  1  to Register_File write_enable
write_addr  out  ADDR_WIDTH  to Register_File write_addr
write_data  out  DATA_WIDTH  to Register_File write_data
busy_mask  out  2**ADDR_WIDTH  scoreboard state, bit i = register i pending

Behaviour:
- Reset (rst=1 at edge): write_enable=0, write_addr=0, write_data=0, busy_mask=0, starve_cnt=0.
- While rst=1, alu_ready=0 and mem_ready=0. Requests in flight at reset are dropped, not replayed.
- Grant is combinational. Default: mem wins when both are valid.
- If alu_valid=1 and starve_cnt==STARVE_LIMIT, ALU wins instead.
- A lone valid requester is always granted. Ready is never asserted without the matching valid.
- starve_cnt (3 bits): increments on each edge where alu_valid=1 and alu is not granted. It clears to 0 when alu is granted or alu_valid=0. It saturates at STARVE_LIMIT.
- Transfer happens on an edge where valid&ready. Requesters must hold addr/data stable until their ready is seen.
- Write port latency is 1 cycle. The edge that accepts a transfer registers write_addr/write_data from the winner. At the same edge, write_enable is set to 1 if the winner's addr != 0, else 0.
- With no transfer, write_enable=0 next cycle; write_addr/write_data hold their last value.
- Register 0: a write to it is accepted (ready asserted) but never enables a write. It is never marked busy.
- Scoreboard set: busy_mask[issue_addr] sets at the edge where issue_valid=1 and issue_addr!=0.
- Scoreboard clear: busy_mask[a] clears at the edge where a transfer with addr a is accepted.
- Simultaneous set and clear of the same address: set wins, so the bit stays 1 for the newer instruction.
- Set and clear of different addresses in the same cycle both take effect.
- hazard1 = busy_mask[read_addr1] and hazard2 = busy_mask[read_addr2], combinational from the registered mask. Address 0 always yields 0.
- Writes to a non-busy register are still performed; the scoreboard bit stays 0.
- Both requesters targeting the same address in one cycle: only the winner transfers. The loser waits and transfers later, and its later write overwrites the first.

Test Plan:
- Reset check: rst=1 for 2 cycles with alu_valid=1 -> alu_ready=0, write_enable=0, busy_mask=0, hazard1=hazard2=0.
- Single write: issue_addr=5 with issue_valid; next cycle read_addr1=5 -> hazard1=1. Then alu_valid, alu_addr=5, alu_data=32'h100 -> alu_ready=1; next cycle write_enable=1, write_addr=5, write_data=32'h100, hazard1=0.
- Priority and starvation (STARVE_LIMIT=3): alu_valid and mem_valid held high for 5 cycles with distinct addresses -> mem granted cycles 0-2, alu granted cycle 3, mem granted cycle 4; starve_cnt back to 0 after cycle 3.
- Register 0: mem_valid, mem_addr=0, mem_data=32'hFFFF_FFFF -> mem_ready=1, next-cycle write_enable=0. issue_valid with issue_addr=0 -> busy_mask stays 0.
- Set/clear collision: busy_mask[16]=1; same cycle issue_addr=16 with issue_valid and alu write to 16 accepted -> write_enable=1 to addr 16 next cycle, busy_mask[16] remains 1.
- Reset mid-operation: busy_mask=32'h0000_0104 with mem_valid high; assert rst one cycle -> busy_mask=0, write_enable=0, mem_ready=0 during rst; normal grants resume after rst falls.
